// File: rtl/aes_pkg.sv
// Shared definitions for the AES front-end loader: block width, loader
// state encoding and the words-per-block helper.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_e;

  // Number of WORD_W-bit words making up one 128-bit block.
  function automatic int unsigned aes_words(input int unsigned word_w);
    return AES_BLK_W / word_w;
  endfunction

endpackage

// File: rtl/aes_block_loader_if.sv
// Stream-in / block-out bus of the AES block loader.
//   master : word source and block consumer (drives in_*, flush, blk_ready)
//   slave  : the loader (drives in_ready, blk_valid, data_out, key_out,
//            key_loaded, err_ovf)
interface aes_block_loader_if #(
  parameter int unsigned WORD_W = 32
) ();
  import aes_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WORD_W-1:0]    in_word;
  logic                 in_is_key;
  logic                 flush;
  logic                 blk_valid;
  logic                 blk_ready;
  logic [AES_BLK_W-1:0] data_out;
  logic [AES_BLK_W-1:0] key_out;
  logic                 key_loaded;
  logic                 err_ovf;

  modport master (
    output in_valid, in_word, in_is_key, flush, blk_ready,
    input  in_ready, blk_valid, data_out, key_out, key_loaded, err_ovf
  );

  modport slave (
    input  in_valid, in_word, in_is_key, flush, blk_ready,
    output in_ready, blk_valid, data_out, key_out, key_loaded, err_ovf
  );

endinterface

// File: rtl/aes_word_packer.sv
// Packs a stream of WORD_W-bit words into a 128-bit shift register
// (first word ends up in the MSBs).
// Macro AES_LOADER_BSWAP_EN: byte-reverse each word before shifting it in.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the word counter (register contents kept)
//   load       : a word is accepted this cycle
//   word       : incoming word
//   sreg       : 128-bit shift register
//   cnt        : words collected
//   complete   : WRAP=1: a full set was collected since the last restart
//                WRAP=0: counter saturated at WORDS, further loads dropped
module aes_word_packer
  import aes_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter bit          WRAP   = 1'b0,
  localparam int unsigned WORDS = aes_words(WORD_W),
  localparam int unsigned CNT_W = $clog2(WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 load,
  input  logic [WORD_W-1:0]    word,
  output logic [AES_BLK_W-1:0] sreg,
  output logic [CNT_W-1:0]     cnt,
  output logic                 complete
);

  logic [WORD_W-1:0] word_sw;
  logic              at_last;
  logic              full;
  logic              shift_en;

`ifdef AES_LOADER_BSWAP_EN
  // Byte reversal for little-endian hosts.
  always_comb begin
    word_sw = '0;
    for (int b = 0; b < int'(WORD_W / 8); b++) begin
      word_sw[b*8 +: 8] = word[WORD_W-8-b*8 +: 8];
    end
  end
`else
  assign word_sw = word;
`endif

  assign at_last  = (cnt == CNT_W'(WORDS - 1));
  assign full     = (cnt == CNT_W'(WORDS));
  // A saturated counter drops the word; in wrap mode full never occurs.
  assign shift_en = load && !full;

  // Shift register and word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (shift_en) begin
      sreg <= {sreg[AES_BLK_W-WORD_W-1:0], word_sw};
      cnt  <= (WRAP && at_last) ? '0 : cnt + CNT_W'(1);
    end
  end

  if (WRAP) begin : g_wrap
    logic done_q;
    // Set on the last word of a set, cleared when a new set starts.
    always_ff @(posedge clk) begin
      if (reset) begin
        done_q <= 1'b0;
      end else if (shift_en && at_last) begin
        done_q <= 1'b1;
      end else if (shift_en && (cnt == '0)) begin
        done_q <= 1'b0;
      end
    end
    assign complete = done_q;
  end else begin : g_sat
    assign complete = full;
  end

endmodule

// File: rtl/aes_block_loader.sv
// Upstream feeder for the AES-128 core: collects key and plaintext words,
// then presents a {data, key} pair until the core takes it. The key is kept
// across blocks until a new one is streamed in.
// Macro AES_LOADER_BSWAP_EN: byte-reverse incoming words (WORD_W >= 16).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : aes_block_loader_if.slave (word stream in, block out)
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  aes_block_loader_if.slave  bus
);

  localparam int unsigned WORDS = aes_words(WORD_W);
  localparam int unsigned CNT_W = $clog2(WORDS + 1);

  loader_state_e          state;
  loader_state_e          state_next;
  logic                   data_clr;
  logic                   accept;
  logic                   key_ld;
  logic                   data_ld;
  logic                   data_full;
  logic                   key_loaded;
  logic                   blk_valid_q;
  logic                   err_ovf_q;
  logic [CNT_W-1:0]       key_cnt;
  logic [CNT_W-1:0]       data_cnt_unused;
  logic [AES_BLK_W-1:0]   key_sreg;
  logic [AES_BLK_W-1:0]   data_sreg;

  assign bus.in_ready = (state == FILL) && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign key_ld       = accept && bus.in_is_key;
  assign data_ld      = accept && !bus.in_is_key;

  aes_word_packer #(.WORD_W(WORD_W), .WRAP(1'b1)) u_key (
    .clk      (clk),
    .reset    (reset),
    .clr      (1'b0),
    .load     (key_ld),
    .word     (bus.in_word),
    .sreg     (key_sreg),
    .cnt      (key_cnt),
    .complete (key_loaded)
  );

  aes_word_packer #(.WORD_W(WORD_W), .WRAP(1'b0)) u_data (
    .clk      (clk),
    .reset    (reset),
    .clr      (data_clr),
    .load     (data_ld),
    .word     (bus.in_word),
    .sreg     (data_sreg),
    .cnt      (data_cnt_unused),
    .complete (data_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next state and data-counter clear.
  always_comb begin
    state_next = state;
    data_clr   = 1'b0;
    case (state)
      FILL: begin
        if (bus.flush) begin
          data_clr = 1'b1;
        end
        // A key mid-reload (counter non-zero) blocks the pair.
        if (data_full && key_loaded && (key_cnt == '0)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.blk_ready) begin
          data_clr   = 1'b1;
          state_next = FILL;
        end
      end
    endcase
  end

  // Registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_valid_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      blk_valid_q <= (state_next == HOLD);
      err_ovf_q   <= data_ld && data_full;
    end
  end

  assign bus.blk_valid  = blk_valid_q;
  assign bus.err_ovf    = err_ovf_q;
  assign bus.key_loaded = key_loaded;
  assign bus.data_out   = data_sreg;
  assign bus.key_out    = key_sreg;

endmodule

// File: tb/tb_aes_block_loader.sv
// Bench for aes_block_loader: directed scenarios followed by random traffic,
// checked against a word-level reference model and a block scoreboard.
module tb_aes_block_loader;
  import aes_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned NW = 128 / W;

  localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2 = 128'hffeeddccbbaa99887766554433221100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_block_loader_if #(.WORD_W(W)) bus ();

  aes_block_loader #(.WORD_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: completed-key flag, words in the current key and
  // plaintext, and the 128-bit value formed by the most recent words.
  bit           m_hold, m_kdone, m_err;
  int           kn, dn;
  logic [127:0] m_kreg, m_dreg;
  logic [255:0] sb[$];
  bit           mon_en = 1'b0;

  bit           cur_v, cur_k, cur_f, cur_r, cur_rst;
  logic [W-1:0] cur_w;
  bit           e_ready, e_valid, e_kl, e_err;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Apply the effect of one clock edge with the inputs held this cycle.
  function automatic void model_step();
    bit acc;
    bit go;
    if (cur_rst) begin
      m_hold = 0; m_kdone = 0; m_err = 0; kn = 0; dn = 0;
      m_kreg = '0; m_dreg = '0;
      sb.delete();
      mon_en = 1'b1;
      return;
    end
    m_err = 0;
    if (m_hold) begin
      if (cur_r) begin
        m_hold = 0;
        dn = 0;
      end
      return;
    end
    go  = (dn == int'(NW)) && m_kdone && (kn == 0);
    acc = cur_v && !cur_f;
    if (acc && cur_k) begin
      if (kn == 0) m_kdone = 0;
      m_kreg = (m_kreg << W) | 128'(cur_w);
      kn++;
      if (kn == int'(NW)) begin
        kn = 0;
        m_kdone = 1;
      end
    end else if (acc) begin
      if (dn == int'(NW)) begin
        m_err = 1;
      end else begin
        m_dreg = (m_dreg << W) | 128'(cur_w);
        dn++;
      end
    end
    if (cur_f) dn = 0;
    if (go) begin
      m_hold = 1;
      sb.push_back({m_dreg, m_kreg});
    end
  endfunction

  // One clock cycle: advance the model past the edge, then drive new inputs.
  task automatic cyc(input bit v, input bit k, input logic [W-1:0] w,
                     input bit f, input bit r, input bit rst);
    @(posedge clk);
    model_step();
    #1;
    bus.in_valid  = v;
    bus.in_is_key = k;
    bus.in_word   = w;
    bus.flush     = f;
    bus.blk_ready = r;
    reset         = rst;
    cur_v = v; cur_k = k; cur_w = w; cur_f = f; cur_r = r; cur_rst = rst;
    e_ready = !m_hold && !f;
    e_valid = m_hold;
    e_kl    = m_kdone;
    e_err   = m_err;
  endtask

  task automatic idle(input bit r, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, r, 1'b0);
  endtask

  task automatic send_blk(input logic [127:0] val, input bit is_key, input bit r);
    logic [W-1:0] w;
    for (int i = 0; i < int'(NW); i++) begin
      w = val[127 - W*i -: W];
      cyc(1'b1, is_key, w, 1'b0, r, 1'b0);
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);
  endtask

  // Monitor: per-cycle status checks plus scoreboard pop on each handshake.
  always @(negedge clk) begin
    if (mon_en) begin
      check("in_ready",   128'(bus.in_ready),   128'(e_ready));
      check("blk_valid",  128'(bus.blk_valid),  128'(e_valid));
      check("key_loaded", 128'(bus.key_loaded), 128'(e_kl));
      check("err_ovf",    128'(bus.err_ovf),    128'(e_err));
      if (bus.blk_valid && bus.blk_ready) begin
        check("blk_expected", 128'(sb.size() != 0), 128'd1);
        if (sb.size() != 0) begin
          logic [255:0] e;
          e = sb.pop_front();
          check("sb_data", bus.data_out, e[255:128]);
          check("sb_key",  bus.key_out,  e[127:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_is_key = 1'b0; bus.in_word = '0;
    bus.flush = 1'b0; bus.blk_ready = 1'b0;
    cur_v = 0; cur_k = 0; cur_w = '0; cur_f = 0; cur_r = 0; cur_rst = 1;

    // Reset state.
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);
    check("rst_data", bus.data_out, '0);
    check("rst_key",  bus.key_out,  '0);
    check("rst_ready", 128'(bus.in_ready), 128'd1);

    // Key then data: pair appears one cycle after the last accept.
    send_blk(K, 1'b1, 1'b1);
    send_blk(P, 1'b0, 1'b1);
    idle(1'b1, 1);
    check("t1_early", 128'(bus.blk_valid), 128'd0);
    idle(1'b1, 1);
    check("t1_valid", 128'(bus.blk_valid), 128'd1);
    check("t1_key",   bus.key_out,  K);
    check("t1_data",  bus.data_out, P);
    check("t1_ready", 128'(bus.in_ready), 128'd0);
    idle(1'b1, 1);

    // Data before key: nothing until the key completes.
    do_reset();
    send_blk(P, 1'b0, 1'b1);
    idle(1'b1, 3);
    check("t2_wait", 128'(bus.blk_valid), 128'd0);
    send_blk(K, 1'b1, 1'b1);
    idle(1'b1, 2);
    check("t2_valid", 128'(bus.blk_valid), 128'd1);
    check("t2_key",   bus.key_out,  K);
    check("t2_data",  bus.data_out, P);
    idle(1'b1, 1);

    // Key reuse for a second block.
    send_blk(P2, 1'b0, 1'b1);
    idle(1'b1, 2);
    check("t3_valid", 128'(bus.blk_valid), 128'd1);
    check("t3_key",   bus.key_out,  K);
    check("t3_data",  bus.data_out, P2);
    check("t3_kl",    128'(bus.key_loaded), 128'd1);
    idle(1'b1, 1);

    // Flush discards a partial plaintext.
    cyc(1'b1, 1'b0, 32'hdeadbeef, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'hcafef00d, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    send_blk(P, 1'b0, 1'b1);
    idle(1'b1, 2);
    check("t4_valid", 128'(bus.blk_valid), 128'd1);
    check("t4_data",  bus.data_out, P);
    idle(1'b1, 1);

    // Overflow word while the key is missing.
    do_reset();
    send_blk(P, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    check("t5_err", 128'(bus.err_ovf), 128'd1);
    idle(1'b0, 1);
    check("t5_err_end", 128'(bus.err_ovf), 128'd0);
    send_blk(K, 1'b1, 1'b0);
    idle(1'b0, 2);
    check("t5_valid", 128'(bus.blk_valid), 128'd1);
    check("t5_data",  bus.data_out, P);

    // Core stalls, then reset arrives mid-hold.
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 1);
      check("t6_hold_data", bus.data_out, P);
      check("t6_hold_key",  bus.key_out,  K);
    end
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1);
    check("t6_valid", 128'(bus.blk_valid),  128'd0);
    check("t6_kl",    128'(bus.key_loaded), 128'd0);
    check("t6_ready", 128'(bus.in_ready),   128'd1);
    idle(1'b0, 4);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit v, k, f, r, rs;
      v  = ($urandom_range(0, 9) < 7);
      k  = ($urandom_range(0, 9) < 3);
      f  = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 299) == 0);
      cyc(v, k, W'($urandom), f, r, rs);
    end

    // Drain any pending pair.
    idle(1'b1, 3);
    @(negedge clk);
    #1;
    check("sb_drain", 128'(sb.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Upstream feeder for the AES-128 encryption core.
- Accepts plaintext and cipher key as a stream of WORD_W-bit words over a valid/ready handshake, and packs them into 128-bit registers.
- Presents a complete {data, key} pair to the core with a valid/ready handshake.
- Holds the key across blocks, so a key is loaded once and reused until a new one is streamed in.

Parameters:
- WORD_W, 32, input word width; legal values 8, 16, 32, 64.
- WORDS, 128/WORD_W, derived local constant: words per 128-bit block; not overridable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  in_word/in_is_key valid
- in_ready  output  1  loader can accept a word this cycle
- in_word  input  WORD_W  word; first word of a block is bits [127:128-WORD_W] (FIPS-197 byte order)
- in_is_key  input  1  1 = key word, 0 = plaintext word
- flush  input  1  discard partially loaded plaintext
- blk_valid  output  1  data_out/key_out hold a complete pair
- blk_ready  input  1  core consumes the pair
- data_out  output  128  assembled plaintext
- key_out  output  128  assembled key
- key_loaded  output  1  a complete key is present
- err_ovf  output  1  one-cycle pulse: plaintext word dropped

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - All outputs 0, except in_ready = 1.
  - State FILL; both word counters 0; key_loaded = 0.
- State FILL:
  - in_ready = !flush. A word is accepted when in_valid && in_ready.
  - Key word: shift into the key register (shift left by WORD_W, insert at LSBs) and increment the key counter.
    - The first key word of a key (counter 0) clears key_loaded.
    - When the counter reaches WORDS-1 and accepts, set key_loaded = 1 and reset the counter to 0.
  - Data word: same shift scheme on the data register.
    - Increment the data counter, saturating at WORDS (data_full).
    - A data word accepted while data_full is dropped, and err_ovf pulses on the next cycle.
  - Transition to HOLD on the cycle after (data_full && key_loaded && key counter == 0). blk_valid rises in that same cycle.
  - Latency: last required word accepted at edge N gives blk_valid = 1 after edge N+1.
- State HOLD:
  - in_ready = 0; blk_valid = 1.
  - data_out and key_out are stable until the handshake.
  - On blk_valid && blk_ready: data counter = 0, blk_valid = 0, return to FILL. key_loaded stays 1.
- flush:
  - In FILL: data counter = 0 next cycle; the key register and key counter are unaffected.
  - In HOLD: ignored.
- Data fills before the key is complete: remain in FILL; key words are still accepted; HOLD is entered once the key completes.
- Reset mid-operation: all state returns to reset values next cycle, including key_loaded and any pending blk_valid.
- data_out and key_out always reflect the shift registers. They are defined only while blk_valid = 1.

Optional Feature:
- Macro: AES_LOADER_BSWAP_EN.
- Defined: each accepted in_word is byte-reversed before it is shifted in, for little-endian hosts. Requires WORD_W ≥ 16.
- Undefined: words are shifted in unchanged.

Decomposition:
- Shared package aes_pkg:
  - AES_BLK_W = 128.
  - Loader state enum {FILL, HOLD}.
  - Function computing WORDS from WORD_W.
- Sub-module aes_word_packer, instantiated twice (key and data). It contains:
  - the 128-bit shift register;
  - the word counter;
  - an optional byte swap;
  - a clear input;
  - a "complete" flag.

Test Plan (WORD_W = 32; key K = 000102030405060708090a0b0c0d0e0f, plaintext P = 00112233445566778899aabbccddeeff):
- Stream 4 key words, then 4 data words, with blk_ready = 1 → blk_valid high exactly 1 cycle after the 8th accept; key_out = K; data_out = P; in_ready = 0 while blk_valid = 1.
- 4 data words first, then 4 key words → no blk_valid until after the 4th key word; then key_out = K and data_out = P.
- After one block handshake, stream a second plaintext 0xffeeddccbbaa99887766554433221100 without any key words → blk_valid with key_out = K still; key_loaded stays 1.
- 2 data words, flush pulse, then 4 fresh data words → data_out equals only the fresh words.
- A 5th data word while the key is missing → err_ovf pulses for 1 cycle; data_out unchanged.
- blk_ready held 0 for 10 cycles, with reset asserted in cycle 5 → outputs stable until reset; then blk_valid = 0, key_loaded = 0, in_ready = 1.
